// File: rtl/i2s_pkg.sv
// Shared constants and FSM encoding for the I2S frame scheduler.
// Sample width, slot count and the scheduler state type live here.
package i2s_pkg;

  localparam int SAMPLE_BITS         = 16;
  localparam int SLOTS_PER_CH        = 16;
  localparam int SCLK_PER_LR         = 2 * SLOTS_PER_CH;
  localparam int MCLK_TO_LRCLK_RATIO = 512;
  localparam int FRAME_BITS          = 2 * SAMPLE_BITS;
  localparam int CNT_W               = $clog2(SAMPLE_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

endpackage

// File: rtl/i2s_frame_arbiter.sv
// One-entry next-frame buffer fed by two sources.
// src0 has fixed priority over src1.
module i2s_frame_arbiter
  import i2s_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FRAME_BITS-1:0] src0_frame_i,
  input  logic                  src0_valid_i,
  output logic                  src0_ready_o,
  input  logic [FRAME_BITS-1:0] src1_frame_i,
  input  logic                  src1_valid_i,
  output logic                  src1_ready_o,
  input  logic                  drain_i,
  output logic                  buf_full_o,
  output logic                  buf_src_o,
  output logic [FRAME_BITS-1:0] buf_frame_o
);

  logic                  full_q, full_d;
  logic                  src_q, src_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  xfer0, xfer1;

  assign src0_ready_o = ~full_q & ~rst_i;
  assign src1_ready_o = ~full_q & ~rst_i & ~src0_valid_i;

  assign xfer0 = src0_valid_i & src0_ready_o;
  assign xfer1 = src1_valid_i & src1_ready_o;

  always_comb begin
    full_d  = full_q;
    src_d   = src_q;
    frame_d = frame_q;
    if (drain_i) full_d = 1'b0;
    // a refill in the drain cycle leaves the new frame buffered
    if (xfer0) begin
      full_d  = 1'b1;
      src_d   = 1'b0;
      frame_d = src0_frame_i;
    end else if (xfer1) begin
      full_d  = 1'b1;
      src_d   = 1'b1;
      frame_d = src1_frame_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      src_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      full_q  <= full_d;
      src_q   <= src_d;
      frame_q <= frame_d;
    end
  end

  assign buf_full_o  = full_q;
  assign buf_src_o   = src_q;
  assign buf_frame_o = frame_q;

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Arbitrates stereo frames and serialises them MSB-first in I2S format,
// aligned to the sclk/lrclk levels produced by i2s_controller.
module i2s_frame_scheduler
  import i2s_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  lrclk,
  input  logic [FRAME_BITS-1:0] src0_frame,
  input  logic                  src0_valid,
  output logic                  src0_ready,
  input  logic [FRAME_BITS-1:0] src1_frame,
  input  logic                  src1_valid,
  output logic                  src1_ready,
  output logic                  sdata,
  output logic                  frame_start,
  output logic                  underrun,
  output logic                  active_src
);

  state_e                 state_q, state_d;
  logic                   sclk_q, lrclk_q, fall_q, lr_last_q;
  logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  cur_q, cur_d;
  logic                   sdata_q, sdata_d;
  logic                   fs_q, fs_d;
  logic                   ur_q, ur_d;
  logic                   act_q, act_d;
  logic                   drain;
  logic                   buf_full, buf_src;
  logic [FRAME_BITS-1:0]  buf_frame;
  logic                   lr_edge;

  i2s_frame_arbiter u_arb (
    .clk_i        (clk),
    .rst_i        (rst),
    .src0_frame_i (src0_frame),
    .src0_valid_i (src0_valid),
    .src0_ready_o (src0_ready),
    .src1_frame_i (src1_frame),
    .src1_valid_i (src1_valid),
    .src1_ready_o (src1_ready),
    .drain_i      (drain),
    .buf_full_o   (buf_full),
    .buf_src_o    (buf_src),
    .buf_frame_o  (buf_frame)
  );

  assign lr_edge = lrclk_q ^ lr_last_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    sdata_d = sdata_q;
    act_d   = act_q;
    fs_d    = 1'b0;
    ur_d    = 1'b0;
    drain   = 1'b0;
    if (fall_q) begin
      sdata_d = 1'b0;
      if (state_q != IDLE && cnt_q < CNT_W'(SAMPLE_BITS)) begin
        sdata_d = shreg_q[SAMPLE_BITS-1];
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      if (lr_edge && !lrclk_q) begin
        state_d = LEFT;
        fs_d    = 1'b1;
        cnt_d   = '0;
        if (buf_full) begin
          cur_d   = buf_frame;
          act_d   = buf_src;
          drain   = 1'b1;
          shreg_d = buf_frame[FRAME_BITS-1:SAMPLE_BITS];
        end else begin
          cur_d   = '0;
          ur_d    = 1'b1;
          shreg_d = '0;
        end
      end else if (lr_edge && state_q != IDLE) begin
        state_d = RIGHT;
        cnt_d   = '0;
        shreg_d = cur_q[SAMPLE_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      fall_q    <= 1'b0;
      lr_last_q <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      cur_q     <= '0;
      sdata_q   <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
      act_q     <= 1'b0;
    end else begin
      sclk_q  <= sclk;
      lrclk_q <= lrclk;
      fall_q  <= sclk_q & ~sclk;
      if (fall_q) lr_last_q <= lrclk_q;
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      sdata_q <= sdata_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
      act_q   <= act_d;
    end
  end

  assign sdata       = sdata_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;
  assign active_src  = act_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Scoreboard bench for i2s_frame_scheduler with a local sclk/lrclk
// generator (4 clk per sclk, 32 sclk per lrclk half).
module tb_i2s_frame_scheduler;

  localparam int FRAME = 256;

  typedef struct packed {
    logic [31:0] frame;
    logic        src;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk = 1'b1;
  logic        lrclk = 1'b1;
  logic [1:0]  gph = 2'd0;
  logic [4:0]  gslot = 5'd0;
  logic [31:0] src0_frame, src1_frame;
  logic        src0_valid, src1_valid;
  logic        src0_ready, src1_ready;
  logic        sdata, frame_start, underrun, active_src;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        q[$];
  exp_t        cur;
  logic        cur_valid = 1'b0;
  logic        last_src = 1'b0;
  logic        nz = 1'b0;
  logic [15:0] word = '0;
  logic        hs0, hs1, hs0_flag = 1'b0;
  logic        mpt, entry, under;
  logic        rnd0 = 1'b0;

  i2s_frame_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .lrclk       (lrclk),
    .src0_frame  (src0_frame),
    .src0_valid  (src0_valid),
    .src0_ready  (src0_ready),
    .src1_frame  (src1_frame),
    .src1_valid  (src1_valid),
    .src1_ready  (src1_ready),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun),
    .active_src  (active_src)
  );

  always #4 clk = ~clk;

  always @(posedge clk) begin
    gph <= gph + 2'd1;
    if (gph == 2'd1) begin
      sclk  <= 1'b0;
      gslot <= gslot + 5'd1;
      if (gslot == 5'd31) lrclk <= ~lrclk;
    end
    if (gph == 2'd3) sclk <= 1'b1;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cur_valid = 1'b0;
      last_src  = 1'b0;
      hs0_flag  = 1'b0;
      check("rst_sdata", sdata, 0);
      check("rst_fstart", frame_start, 0);
      check("rst_underrun", underrun, 0);
      check("rst_src", active_src, 0);
      check("rst_ready", {src0_ready, src1_ready}, 0);
    end else begin
      hs0 = src0_valid & src0_ready;
      hs1 = src1_valid & src1_ready;
      hs0_flag = hs0;
      if (hs1) check("prio", src0_valid, 0);
      if (hs0) q.push_back({src0_frame, 1'b0});
      else if (hs1) q.push_back({src1_frame, 1'b1});
      mpt   = (gph == 2'd0);
      entry = mpt && gslot == 5'd0 && !lrclk;
      check("fstart", frame_start, entry);
      if (entry) begin
        if (cur_valid) check("pad_zero", nz | sdata, 0);
        if (q.size() > 0) begin
          cur   = q.pop_front();
          under = 1'b0;
        end else begin
          cur   = '{frame: 32'h0, src: last_src};
          under = 1'b1;
        end
        check("underrun", underrun, under);
        check("active_src", active_src, cur.src);
        last_src  = cur.src;
        cur_valid = 1'b1;
        nz        = 1'b0;
      end else begin
        check("underrun", underrun, 0);
        if (mpt) begin
          if (!cur_valid) begin
            check("idle_sdata", sdata, 0);
          end else if (gslot >= 5'd1 && gslot <= 5'd16) begin
            word = {word[14:0], sdata};
            if (gslot == 5'd16) begin
              if (lrclk) check("right", word, cur.frame[15:0]);
              else check("left", word, cur.frame[31:16]);
            end
          end else begin
            nz = nz | sdata;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd0 && hs0_flag) src0_frame = $urandom;
  endtask

  task automatic wait_slot(logic lr, logic [4:0] slot);
    int n = 0;
    while (!(lrclk == lr && gslot == slot)) begin
      step();
      n++;
      if (n > 2000) begin
        check("timeout", 1, 0);
        break;
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    src0_frame = 32'hA5C3_0F0F;
    src1_frame = 32'h8001_7FFE;
    src0_valid = 1'b1;
    src1_valid = 1'b0;
    repeat (10) step();
    rst = 1'b0;
    wait_slot(1'b0, 5'd2);
    repeat (3 * FRAME) step();

    wait_slot(1'b0, 5'd2);
    src0_valid = 1'b0;
    src1_valid = 1'b1;
    repeat (3 * FRAME) step();

    wait_slot(1'b0, 5'd2);
    src0_valid = 1'b1;
    rnd0 = 1'b1;
    repeat (3 * FRAME) step();

    wait_slot(1'b0, 5'd2);
    rnd0 = 1'b0;
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    repeat (5 * FRAME) step();

    wait_slot(1'b0, 5'd2);
    src0_frame = 32'h1234_8765;
    src0_valid = 1'b1;
    wait_slot(1'b1, 5'd10);
    rst = 1'b1;
    src0_frame = $urandom;
    repeat (3) step();
    rst = 1'b0;
    repeat (3 * FRAME) step();

    wait_slot(1'b0, 5'd5);
    rst = 1'b1;
    src0_frame = 32'hC0DE_F00D;
    repeat (3) step();
    rst = 1'b0;
    repeat (3 * FRAME) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
